bus_arbiter: RTL and testbench

Round-robin arbiter that shares the single processor memory bus (the address, write-data and write-enable bus feeding the memory map) among `NUM_REQ` masters, such as the CPU and a framebuffer fill/blit engine. It owns the bus for one requester at a time and grants bursts of up to `MAX_BURST` beats. It returns read data to the requester that issued the read, one cycle after the beat is accepted, matching the synchronous-read memories behind the map.

---
 rtl/bus_arbiter_if.sv | 29 ++
 rtl/bus_arbiter.sv | 116 +++++++++++
 tb/tb_bus_arbiter.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_arbiter_if.sv
// Memory-bus bundle shared by the requesters, the arbiter and the memory map.
// Per-requester fields are packed so requester i occupies bits [32i+31:32i].
interface bus_arbiter_if #(
  parameter int NUM_REQ = 2
);
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ-1:0][31:0] req_addr;
  logic [NUM_REQ-1:0][31:0] req_wr_data;
  logic [NUM_REQ-1:0]       req_wr_en;
  logic [NUM_REQ-1:0]       gnt;
  logic [NUM_REQ-1:0]       rd_valid;
  logic [31:0]              rd_data;
  logic [31:0]              bus_addr;
  logic [31:0]              bus_wr_data;
  logic                     bus_wr_en;
  logic [31:0]              bus_rd_data;

  // Arbiter side.
  modport slave (
    input  req, req_addr, req_wr_data, req_wr_en, bus_rd_data,
    output gnt, rd_valid, rd_data, bus_addr, bus_wr_data, bus_wr_en
  );

  // Requesters plus memory map.
  modport master (
    output req, req_addr, req_wr_data, req_wr_en, bus_rd_data,
    input  gnt, rd_valid, rd_data, bus_addr, bus_wr_data, bus_wr_en
  );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin owner of the single memory bus; bursts capped at MAX_BURST beats.
// Read data is steered back to the issuing requester one cycle after acceptance.
module bus_arbiter #(
  parameter int NUM_REQ   = 2,
  parameter int MAX_BURST = 16
) (
  input  logic         clk,
  input  logic         rst,
  bus_arbiter_if.slave bif
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, OWNED} state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [IW-1:0] last_owner_q, last_owner_d;
  logic [IW-1:0] rd_owner_q, rd_owner_d;
  logic [CW-1:0] burst_cnt_q, burst_cnt_d;
  logic          rd_pend_q, rd_pend_d;

  logic [IW-1:0] sel;
  logic          sel_vld;
  logic          beat;
  logic          last_beat;

  // Scan from the farthest candidate down so the nearest one after last_owner wins.
  always_comb begin
    sel     = '0;
    sel_vld = 1'b0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      int idx;
      idx = (int'(last_owner_q) + k) % NUM_REQ;
      if (bif.req[IW'(idx)]) begin
        sel     = IW'(idx);
        sel_vld = 1'b1;
      end
    end
  end

  assign beat      = (state_q == OWNED) && bif.req[owner_q];
  assign last_beat = (burst_cnt_q == CW'(MAX_BURST - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= '0;
      last_owner_q <= IW'(NUM_REQ - 1);
      rd_owner_q   <= '0;
      burst_cnt_q  <= '0;
      rd_pend_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      rd_owner_q   <= rd_owner_d;
      burst_cnt_q  <= burst_cnt_d;
      rd_pend_q    <= rd_pend_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    rd_owner_d   = rd_owner_q;
    burst_cnt_d  = burst_cnt_q;
    rd_pend_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (sel_vld) begin
          owner_d     = sel;
          burst_cnt_d = '0;
          state_d     = OWNED;
        end
      end
      OWNED: begin
        if (beat) begin
          burst_cnt_d = burst_cnt_q + 1'b1;
          if (!bif.req_wr_en[owner_q]) begin
            rd_pend_d  = 1'b1;
            rd_owner_d = owner_q;
          end
          if (last_beat) begin
            state_d      = IDLE;
            last_owner_d = owner_q;
          end
        end else begin
          // Owner dropped its request: hand the bus back without a beat.
          state_d      = IDLE;
          last_owner_d = owner_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bif.gnt         = '0;
    bif.bus_addr    = '0;
    bif.bus_wr_data = '0;
    bif.bus_wr_en   = 1'b0;
    bif.rd_valid    = '0;
    if (state_q == OWNED) begin
      bif.gnt[owner_q] = bif.req[owner_q];
      bif.bus_addr     = bif.req_addr[owner_q];
      bif.bus_wr_data  = bif.req_wr_data[owner_q];
      bif.bus_wr_en    = bif.req_wr_en[owner_q] && bif.req[owner_q];
    end
    bif.rd_valid[rd_owner_q] = rd_pend_q;
  end

  assign bif.rd_data = bif.bus_rd_data;

endmodule

// File: tb/tb_bus_arbiter.sv
// Scenario bench for bus_arbiter (MAX_BURST=4); read returns go through a
// cycle-stamped scoreboard checked by a monitor every cycle.
module tb_bus_arbiter;
  localparam int NUM_REQ   = 2;
  localparam int MAX_BURST = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  bit          mon_en = 1'b0;

  typedef struct {
    int unsigned cyc;
    int          idx;
    logic [31:0] data;
  } rd_exp_t;
  rd_exp_t sb[$];

  bus_arbiter_if #(.NUM_REQ(NUM_REQ)) bif ();

  bus_arbiter #(.NUM_REQ(NUM_REQ), .MAX_BURST(MAX_BURST)) dut (
    .clk (clk),
    .rst (rst),
    .bif (bif)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a == 32'h10) ? 32'hDEADBEEF : ((a ^ 32'h5A5A_0000) + 32'h1);
  endfunction

  // Synchronous-read memory model.
  always @(posedge clk) bif.bus_rd_data <= memf(bif.bus_addr);

  // Read-return monitor: exactly the scheduled pulses, nothing else.
  always @(negedge clk) begin : mon
    logic [NUM_REQ-1:0] ev;
    rd_exp_t            e;
    if (mon_en) begin
      ev = '0;
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        errors++;
        $display("FAIL rd_missed: entry for cycle %0d unmatched at cycle %0d", sb[0].cyc, cyc);
        void'(sb.pop_front());
      end
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
        e  = sb.pop_front();
        ev = NUM_REQ'(1) << e.idx;
        checks++;
        if (bif.rd_data !== e.data) begin
          errors++;
          $display("FAIL rd_data cyc=%0d: got %h want %h", cyc, bif.rd_data, e.data);
        end
      end
      checks++;
      if (bif.rd_valid !== ev) begin
        errors++;
        $display("FAIL rd_valid cyc=%0d: got %b want %b", cyc, bif.rd_valid, ev);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_read(input int i);
    sb.push_back('{cyc + 1, i, memf(bif.req_addr[i])});
  endtask

  task automatic do_reset();
    bif.req       = '0;
    bif.req_wr_en = '0;
    rst           = 1'b1;
    tick();
    rst = 1'b0;
    sb.delete();
  endtask

  task automatic test_reset();
    bif.req         = 2'b11;
    bif.req_wr_en   = 2'b00;
    bif.req_addr    = {32'h80, 32'h40};
    bif.req_wr_data = '0;
    rst             = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if ({bif.gnt, bif.bus_addr, bif.bus_wr_data, bif.bus_wr_en, bif.rd_valid} !== '0) begin
        errors++;
        $display("FAIL reset_outputs c=%0d: gnt=%b addr=%h wd=%h we=%b rv=%b want all 0",
                 c, bif.gnt, bif.bus_addr, bif.bus_wr_data, bif.bus_wr_en, bif.rd_valid);
      end
      tick();
      mon_en = 1'b1;
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({bif.gnt, bif.bus_addr, bif.bus_wr_data, bif.bus_wr_en} !== '0) begin
      errors++;
      $display("FAIL first_idle: gnt=%b addr=%h wd=%h we=%b want all 0",
               bif.gnt, bif.bus_addr, bif.bus_wr_data, bif.bus_wr_en);
    end
    tick();
    @(negedge clk);
    checks++;
    if (bif.gnt !== 2'b01) begin
      errors++;
      $display("FAIL first_grant: got %b want 01", bif.gnt);
    end
    exp_read(0);
    tick();
    bif.req = '0;
    @(negedge clk);
    checks++;
    if (bif.gnt !== 2'b00) begin
      errors++;
      $display("FAIL reset_release_gnt: got %b want 00", bif.gnt);
    end
    tick();
  endtask

  task automatic test_read_return();
    do_reset();
    bif.req         = 2'b01;
    bif.req_wr_en   = 2'b00;
    bif.req_addr[0] = 32'h10;
    tick();
    @(negedge clk);
    checks++;
    if (bif.gnt !== 2'b01 || bif.bus_addr !== 32'h10) begin
      errors++;
      $display("FAIL read_addr: gnt=%b addr=%h want 01/00000010", bif.gnt, bif.bus_addr);
    end
    exp_read(0);
    tick();
    bif.req = '0;
    @(negedge clk);
    checks++;
    if (bif.rd_valid !== 2'b01 || bif.rd_data !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL read_return: rv=%b data=%h want 01/deadbeef", bif.rd_valid, bif.rd_data);
    end
    tick();
  endtask

  task automatic test_burst_cap();
    logic [1:0] pat [16] = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10,
                             2'b10, 2'b10, 2'b00, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00};
    do_reset();
    bif.req_wr_en = 2'b00;
    bif.req_addr  = {32'h80, 32'h40};
    for (int c = 0; c < 16; c++) begin
      bif.req = (c < 14) ? 2'b11 : 2'b00;
      @(negedge clk);
      checks++;
      if (bif.gnt !== pat[c]) begin
        errors++;
        $display("FAIL burst_gnt c=%0d: got %b want %b", c, bif.gnt, pat[c]);
      end
      if (pat[c][0]) exp_read(0);
      if (pat[c][1]) exp_read(1);
      tick();
    end
  endtask

  task automatic test_early_release();
    // The release cycle carries no beat, then one IDLE cycle precedes the next grant.
    logic [1:0] rq  [7] = '{2'b10, 2'b11, 2'b11, 2'b01, 2'b01, 2'b01, 2'b00};
    logic [1:0] pat [7] = '{2'b00, 2'b10, 2'b10, 2'b00, 2'b00, 2'b01, 2'b00};
    do_reset();
    bif.req_wr_en = 2'b00;
    bif.req_addr  = {32'h104, 32'h10};
    for (int c = 0; c < 7; c++) begin
      bif.req = rq[c];
      @(negedge clk);
      checks++;
      if (bif.gnt !== pat[c]) begin
        errors++;
        $display("FAIL release_gnt c=%0d: got %b want %b", c, bif.gnt, pat[c]);
      end
      if (pat[c][0]) exp_read(0);
      if (pat[c][1]) exp_read(1);
      tick();
    end
  endtask

  task automatic test_write_path();
    do_reset();
    bif.req            = 2'b10;
    bif.req_wr_en      = 2'b10;
    bif.req_addr[1]    = 32'h20000;
    bif.req_wr_data[1] = 32'hCAFEF00D;
    @(negedge clk);
    checks++;
    if (bif.gnt !== 2'b00 || bif.bus_wr_en !== 1'b0) begin
      errors++;
      $display("FAIL write_idle: gnt=%b we=%b want 00/0", bif.gnt, bif.bus_wr_en);
    end
    tick();
    @(negedge clk);
    checks++;
    if (bif.gnt !== 2'b10 || bif.bus_wr_en !== 1'b1) begin
      errors++;
      $display("FAIL write_grant: gnt=%b we=%b want 10/1", bif.gnt, bif.bus_wr_en);
    end
    checks++;
    if (bif.bus_addr !== 32'h20000 || bif.bus_wr_data !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL write_bus: addr=%h wd=%h want 00020000/cafef00d", bif.bus_addr, bif.bus_wr_data);
    end
    tick();
    bif.req       = '0;
    bif.req_wr_en = '0;
    @(negedge clk);
    checks++;
    if (bif.rd_valid !== 2'b00 || bif.bus_wr_en !== 1'b0) begin
      errors++;
      $display("FAIL write_no_rdvalid: rv=%b we=%b want 00/0", bif.rd_valid, bif.bus_wr_en);
    end
    tick();
  endtask

  task automatic test_reset_mid_read();
    do_reset();
    bif.req         = 2'b01;
    bif.req_wr_en   = 2'b00;
    bif.req_addr    = {32'h104, 32'h10};
    tick();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (bif.gnt !== 2'b01) begin
      errors++;
      $display("FAIL rstmid_accept: got %b want 01", bif.gnt);
    end
    tick();
    rst     = 1'b0;
    bif.req = 2'b11;
    @(negedge clk);
    checks++;
    if (bif.rd_valid !== 2'b00 || bif.gnt !== 2'b00) begin
      errors++;
      $display("FAIL rstmid_drop: rv=%b gnt=%b want 00/00", bif.rd_valid, bif.gnt);
    end
    tick();
    @(negedge clk);
    checks++;
    if (bif.gnt !== 2'b01) begin
      errors++;
      $display("FAIL rstmid_regrant: got %b want 01", bif.gnt);
    end
    exp_read(0);
    tick();
    bif.req = '0;
    @(negedge clk);
    checks++;
    if (bif.gnt !== 2'b00) begin
      errors++;
      $display("FAIL rstmid_tail: got %b want 00", bif.gnt);
    end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bif.req         = '0;
    bif.req_wr_en   = '0;
    bif.req_addr    = '0;
    bif.req_wr_data = '0;
    test_reset();
    test_read_return();
    test_burst_cap();
    test_early_release();
    test_write_path();
    test_reset_mid_read();
    tick();
    tick();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d read returns never seen", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
